// File: rtl/odometer_meas_seq.sv
// Ring-oscillator odometer scan: settle, count and store six rings in turn.
// Define ODO_DIFF_EN to add the signed DIFF_DATA (stress minus reference) output.
module odometer_meas_seq #(
  parameter int SETTLE_CYC = 16,
  parameter int WIN_CYC    = 1024,
  parameter int CNT_W      = 12
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             STRESS_MODE,
  output logic [5:0]       ROSC_SEL_EN,
  output logic [2:0]       ROSC_MUX,
  input  logic             ROSC_DIV,
  output logic             BUSY,
  output logic             DONE,
  input  logic [2:0]       RD_ADDR,
  output logic [CNT_W-1:0] RD_DATA,
  output logic [5:0]       OVF
`ifdef ODO_DIFF_EN
  ,
  output logic signed [CNT_W:0] DIFF_DATA
`endif
);

  localparam int TMAX = (SETTLE_CYC > WIN_CYC) ? SETTLE_CYC : WIN_CYC;
  localparam int TW = $clog2(TMAX + 1);
  localparam logic [CNT_W-1:0] CMAX = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_MEAS, S_STORE, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] res_q [6];
  logic [CNT_W-1:0] res_d [6];
  logic [5:0]       ovf_q, ovf_d;
  logic [2:0]       sync_q, sync_d;
  logic             rise, set_last, win_last;

  // sync_q = {s3, s2, s1}; s1/s2 resynchronise, s3 delays for edge detect
  assign rise     = sync_q[1] & ~sync_q[2];
  assign set_last = tmr_q == TW'(SETTLE_CYC - 1);
  assign win_last = tmr_q == TW'(WIN_CYC - 1);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      tmr_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= '0;
      sync_q  <= '0;
      for (int i = 0; i < 6; i++) res_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tmr_q   <= tmr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      sync_q  <= sync_d;
      for (int i = 0; i < 6; i++) res_q[i] <= res_d[i];
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (START) state_d = S_SETTLE;
      S_SETTLE: if (set_last) state_d = S_MEAS;
      S_MEAS:   if (win_last) state_d = S_STORE;
      S_STORE:  state_d = (idx_q == 3'd5) ? S_DONE : S_SETTLE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    idx_d  = idx_q;
    tmr_d  = tmr_q + TW'(1);
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    sync_d = {sync_q[1:0], ROSC_DIV};
    for (int i = 0; i < 6; i++) res_d[i] = res_q[i];
    unique case (state_q)
      S_IDLE: begin
        tmr_d = '0;
        if (START) begin
          idx_d = '0;
          ovf_d = '0;
        end
      end
      S_SETTLE: begin
        cnt_d = '0;
        if (set_last) tmr_d = '0;
      end
      S_MEAS: begin
        if (rise) begin
          if (cnt_q == CMAX) ovf_d[idx_q] = 1'b1;
          else cnt_d = cnt_q + CNT_W'(1);
        end
        if (win_last) tmr_d = '0;
      end
      S_STORE: begin
        res_d[idx_q] = cnt_q;
        tmr_d = '0;
        if (idx_q != 3'd5) idx_d = idx_q + 3'd1;
      end
      default: tmr_d = '0;
    endcase
  end

  always_comb begin
    ROSC_SEL_EN = '0;
    ROSC_MUX    = '0;
    unique case (state_q)
      S_SETTLE, S_MEAS: begin
        ROSC_SEL_EN = 6'b000001 << idx_q;
        ROSC_MUX    = idx_q;
      end
      S_STORE: ROSC_MUX = idx_q;
      S_IDLE, S_DONE: ROSC_SEL_EN = STRESS_MODE ? 6'b101010 : 6'b000000;
      default: ROSC_SEL_EN = '0;
    endcase
  end

  assign BUSY = state_q != S_IDLE;
  assign DONE = state_q == S_DONE;
  assign OVF  = ovf_q;

  always_comb begin
    RD_DATA = '0;
    for (int i = 0; i < 6; i++)
      if (RD_ADDR == 3'(i)) RD_DATA = res_q[i];
  end

`ifdef ODO_DIFF_EN
  always_comb begin
    DIFF_DATA = '0;
    for (int k = 0; k < 3; k++)
      if (RD_ADDR == 3'(k))
        DIFF_DATA = $signed({1'b0, res_q[2*k+1]})
                  - $signed({1'b0, res_q[2*k]});
  end
`endif

endmodule

// File: doc/odometer_meas_seq.md
ODOMETER_MEAS_SEQ -- requirements
Module: odometer_meas_seq

Interface
REQ-001 The module SHALL have parameter SETTLE_CYC, default 16, which sets the number of cycles a ring is enabled before counting starts (minimum 1).
REQ-002 The module SHALL have parameter WIN_CYC, default 1024, which sets the length of the count window in cycles (minimum 1).
REQ-003 The module SHALL have parameter CNT_W, default 12, which sets the width of each result counter.
REQ-004 Port CLK SHALL be: input, 1 bit, the single clock.
REQ-005 Port RST SHALL be: input, 1 bit, synchronous active-high reset.
REQ-006 Port START SHALL be: input, 1 bit, scan request, sampled only in IDLE.
REQ-007 Port STRESS_MODE SHALL be: input, 1 bit; 1 keeps the stress rings running while idle.
REQ-008 Port ROSC_SEL_EN SHALL be: output, 6 bits, ring enable driven to each ROSC IN; [0] NOR_REF, [1] NOR_STRESS, [2] NAND_REF, [3] NAND_STRESS, [4] INV_REF, [5] INV_STRESS.
REQ-009 Port ROSC_MUX SHALL be: output, 3 bits, index of the ring routed to ROSC_DIV.
REQ-010 Port ROSC_DIV SHALL be: input, 1 bit, muxed and prescaled ring output, asynchronous to CLK.
REQ-011 Port BUSY SHALL be: output, 1 bit, high in every state except IDLE.
REQ-012 Port DONE SHALL be: output, 1 bit, one-cycle pulse at scan end.
REQ-013 Port RD_ADDR SHALL be: input, 3 bits, result read index 0..5.
REQ-014 Port RD_DATA SHALL be: output, CNT_W bits, result[RD_ADDR], combinational read; 0 for RD_ADDR > 5.
REQ-015 Port OVF SHALL be: output, 6 bits, sticky per-channel saturation flags.

Function
REQ-016 The FSM SHALL have exactly the states IDLE, SETTLE, MEAS, STORE and DONE, with a channel index idx in the range 0..5.
REQ-017 In IDLE, START=1 SHALL set idx=0, clear OVF, and move to SETTLE on the next cycle; START SHALL be ignored in all other states.
REQ-018 In SETTLE, ROSC_SEL_EN SHALL be one-hot at bit idx and ROSC_MUX SHALL equal idx; the edge counter SHALL be cleared; after SETTLE_CYC cycles the FSM SHALL move to MEAS.
REQ-019 ROSC_DIV SHALL pass through a 2-flop synchronizer plus one delay flop, and a rising edge SHALL be detected as s2 & ~s3.
REQ-020 In MEAS, every detected edge SHALL increment the counter; the enable and mux outputs SHALL be unchanged from SETTLE; after WIN_CYC cycles the FSM SHALL move to STORE.
REQ-021 The counter SHALL saturate at 2^CNT_W-1, and an increment attempted at saturation SHALL set OVF[idx].
REQ-022 In STORE (one cycle), the counter SHALL be written to result[idx] and ROSC_SEL_EN SHALL be driven to 0; if idx=5 the FSM SHALL go to DONE, otherwise idx SHALL increment and the FSM SHALL go to SETTLE.
REQ-023 DONE SHALL last one cycle with DONE=1, and the FSM SHALL then return to IDLE.
REQ-024 DONE SHALL assert exactly 1+6*(SETTLE_CYC+WIN_CYC+1) cycles after the cycle START is sampled.
REQ-025 In IDLE and DONE, ROSC_SEL_EN SHALL be 6'b101010 when STRESS_MODE=1 and 0 otherwise; ROSC_MUX SHALL be 0.
REQ-026 Stress rings SHALL be disabled during a scan except while their own channel is being measured.
REQ-027 A read during a scan SHALL return the previous scan's value for any channel not yet stored.

Reset
REQ-028 RST=1 at a clock edge SHALL force IDLE, idx=0, counter=0, all result registers=0, OVF=0, sync flops=0, BUSY=0, DONE=0, ROSC_SEL_EN=0 and ROSC_MUX=0.
REQ-029 RST asserted in any state, including mid-MEAS, SHALL abort the scan with no partial result stored.

Configuration
REQ-030 With ODO_DIFF_EN defined, the module SHALL add output DIFF_DATA (CNT_W+1 bits, signed) equal to result[2k+1]-result[2k] for k=RD_ADDR (0..2), and 0 for RD_ADDR > 2.
REQ-031 Without ODO_DIFF_EN, port DIFF_DATA and its subtractor SHALL be absent.

Verification
REQ-032 With SETTLE_CYC=4, WIN_CYC=64, and a ROSC_DIV rising edge every 4 cycles, START SHALL produce RD_DATA of 16±1 for every channel and DONE exactly 415 cycles after START.
REQ-033 With CNT_W=4 and a ROSC_DIV period of 2 cycles over a 64-cycle window, all results SHALL be 15 and OVF SHALL be 6'b111111; the next START SHALL clear OVF.
REQ-034 With STRESS_MODE=1, ROSC_SEL_EN SHALL be 6'b101010 in IDLE, step 000001→100000 during the scan with 0 in each STORE cycle, and return to 101010 after DONE.
REQ-035 RST pulsed during MEAS of idx=3 SHALL give BUSY=0, ROSC_SEL_EN=0 and all RD_DATA=0 on the following cycle.
REQ-036 A START pulse mid-scan SHALL leave DONE timing unchanged, and a START in the DONE cycle SHALL not launch a new scan.
REQ-037 With ODO_DIFF_EN, result[0]=16 and result[1]=12 SHALL give DIFF_DATA=-4 at RD_ADDR=0.
